bp_bht_update_queue: RTL and testbench
======================================

// Module: bp_bht_update_queue
// PURPOSE
//  In-order queue of outstanding branch predictions feeding the BHT update port.
//  Each fetch-time prediction (PC, predicted direction) is recorded here.
//  When the branch resolves in order, the head entry is popped.
//  The queue then drives the BHT write interface: write enable, write PC, and correct = (predicted == actual).
// PARAMETERS
//  PC_W      32  width of branch PC
//  DEPTH_LG  3   log2 of queue depth; DEPTH = 2**DEPTH_LG entries
// PORTS
//  clk_i         in   1          clock
//  reset_i       in   1          reset, asynchronous, active-high
//  flush_i       in   1          squash all outstanding entries (pipeline redirect)
//  pred_v_i      in   1          prediction valid
//  pred_ready_o  out  1          queue can accept a prediction (= ~full)
//  pred_pc_i     in   PC_W       PC of predicted branch
//  pred_taken_i  in   1          predicted direction (1 = taken)
//  res_v_i       in   1          oldest outstanding branch resolved this cycle
//  res_taken_i   in   1          actual direction of resolved branch
//  bht_w_o       out  1          BHT write enable
//  bht_w_pc_o    out  PC_W       BHT write address (PC of resolved branch)
//  correct_o     out  1          prediction was correct
//  count_o       out  DEPTH_LG+1 number of valid entries
//  underflow_o   out  1          sticky: resolution arrived with queue empty
// BEHAVIOUR
//  - Storage: circular buffer of {pc, taken}.
//    rd_ptr/wr_ptr are DEPTH_LG+1 bits wide and wrap modulo 2*DEPTH.
//    empty = ptrs equal; full = low bits equal and MSBs differ.
//  - Push: pred_v_i & pred_ready_o & ~flush_i. Entry written at wr_ptr; wr_ptr+1.
//  - pred_ready_o = ~full. It is registered-state only, with no combinational path from res_v_i.
//    A push while full is therefore refused even if a pop happens in the same cycle.
//  - Pop: res_v_i & ~empty & ~flush_i. Head read at rd_ptr; rd_ptr+1.
//  - Registered update, latency 1: in the cycle after a pop,
//    - bht_w_o = 1
//    - bht_w_pc_o = head pc
//    - correct_o = (head taken == res_taken_i)
//    In all other cycles bht_w_o = 0, and bht_w_pc_o / correct_o hold their last values.
//  - Simultaneous push+pop when not full and not empty: both take effect; count_o unchanged.
//  - No bypass: a push and a res_v_i in the same cycle with the queue empty means the pop is not performed.
//    That case counts as underflow.
//  - Underflow: res_v_i & empty & ~flush_i sets underflow_o, which stays 1 until reset.
//    No BHT write is issued and the pointers are unchanged.
//  - Flush has priority: both pointers clear to 0 and count_o goes to 0 next cycle.
//    Same-cycle push and pop are discarded, and bht_w_o = 0 next cycle.
//    An update registered in the previous cycle still appears on the outputs.
//  - count_o = wr_ptr - rd_ptr, modulo 2*DEPTH; range 0..DEPTH.
//  - Reset (asynchronous, any time including mid-operation): pointers 0, and all outputs as follows:
//    - bht_w_o = 0, bht_w_pc_o = 0, correct_o = 0, count_o = 0
//    - underflow_o = 0, pred_ready_o = 1
//    - entry contents don't-care
// CONFIGURATION
//  BP_UPDQ_STATS_EN defined: adds output mispredict_cnt_o [31:0].
//   - Reset 0; +1 in each cycle where bht_w_o=1 & correct_o=0.
//   - Saturates at 32'hFFFF_FFFF; not cleared by flush_i.
//  BP_UPDQ_STATS_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. Reset, then push pc=0x100 taken=1, next cycle res_v_i taken=1
//     -> the following cycle shows bht_w_o=1, bht_w_pc_o=0x100, correct_o=1, count_o=0.
//  2. Push 0x200 taken=0, resolve taken=1 -> bht_w_o=1, bht_w_pc_o=0x200, correct_o=0.
//     With BP_UPDQ_STATS_EN, mispredict_cnt_o=1.
//  3. DEPTH_LG=3: push 8 entries with no resolve -> count_o=8, pred_ready_o=0.
//     A 9th push is dropped. Then push+pop in the same cycle -> push refused, count_o=7.
//  4. Push 0x10,0x14,0x18, then resolve 3 times on back-to-back cycles
//     -> bht_w_pc_o sequence 0x10,0x14,0x18 with bht_w_o=1 on 3 consecutive cycles.
//     Then push/pop 20 more entries to confirm pointer wrap with no reordering.
//  5. With 4 entries queued, assert flush_i together with res_v_i and pred_v_i
//     -> count_o=0, bht_w_o=0 next cycle.
//     A subsequent res_v_i then sets underflow_o=1, which stays 1.
//  6. With 3 entries queued, assert reset_i mid-stream -> count_o=0 and bht_w_o=0 immediately.
//     After release, push and resolve work from a clean state.

Source files
------------

// File: rtl/bp_bht_update_queue.sv
// In-order queue of fetch-time branch predictions that drives the BHT update port on resolution.
// Optional build macro BP_UPDQ_STATS_EN adds a saturating mispredict counter output.
module bp_bht_update_queue #(
    parameter int PC_W     = 32,
    parameter int DEPTH_LG = 3
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                flush_i,
    input  logic                pred_v_i,
    output logic                pred_ready_o,
    input  logic [PC_W-1:0]     pred_pc_i,
    input  logic                pred_taken_i,
    input  logic                res_v_i,
    input  logic                res_taken_i,
    output logic                bht_w_o,
    output logic [PC_W-1:0]     bht_w_pc_o,
    output logic                correct_o,
    output logic [DEPTH_LG:0]   count_o,
`ifdef BP_UPDQ_STATS_EN
    output logic [31:0]         mispredict_cnt_o,
`endif
    output logic                underflow_o
);

    localparam int DEPTH = 1 << DEPTH_LG;
    localparam logic [DEPTH_LG:0] PTR_ZERO = {(DEPTH_LG+1){1'b0}};
    localparam logic [DEPTH_LG:0] PTR_ONE  = {{DEPTH_LG{1'b0}}, 1'b1};

    logic [PC_W-1:0]     r_mem_pc    [DEPTH];
    logic                r_mem_taken [DEPTH];
    logic [DEPTH_LG:0]   r_rd_ptr;
    logic [DEPTH_LG:0]   r_wr_ptr;
    logic                r_bht_w;
    logic [PC_W-1:0]     r_bht_w_pc;
    logic                r_correct;
    logic                r_underflow;

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_underflow;
    logic [DEPTH_LG-1:0] w_rd_idx;
    logic [DEPTH_LG-1:0] w_wr_idx;

    // Queue status and handshake decode; ready depends only on pointer state.
    always_comb begin
        w_rd_idx    = r_rd_ptr[DEPTH_LG-1:0];
        w_wr_idx    = r_wr_ptr[DEPTH_LG-1:0];
        w_empty     = (r_rd_ptr == r_wr_ptr);
        w_full      = (w_rd_idx == w_wr_idx) && (r_rd_ptr[DEPTH_LG] != r_wr_ptr[DEPTH_LG]);
        w_push      = pred_v_i & ~w_full & ~flush_i;
        w_pop       = res_v_i & ~w_empty & ~flush_i;
        w_underflow = res_v_i & w_empty & ~flush_i;
    end

    // Entry storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_pc[w_wr_idx]    <= pred_pc_i;
            r_mem_taken[w_wr_idx] <= pred_taken_i;
        end
    end

    // Read/write pointers; flush squashes everything outstanding.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rd_ptr <= PTR_ZERO;
            r_wr_ptr <= PTR_ZERO;
        end else if (flush_i) begin
            r_rd_ptr <= PTR_ZERO;
            r_wr_ptr <= PTR_ZERO;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Registered BHT update; PC and correct hold their value between pops.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_bht_w     <= 1'b0;
            r_bht_w_pc  <= {PC_W{1'b0}};
            r_correct   <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_bht_w <= w_pop;
            if (w_pop) begin
                r_bht_w_pc <= r_mem_pc[w_rd_idx];
                r_correct  <= (r_mem_taken[w_rd_idx] == res_taken_i);
            end
            if (w_underflow) r_underflow <= 1'b1;
        end
    end

`ifdef BP_UPDQ_STATS_EN
    logic [31:0] r_mispredict_cnt;

    // Saturating count of issued updates that were mispredictions; survives flush.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_mispredict_cnt <= 32'd0;
        end else if (r_bht_w && !r_correct && (r_mispredict_cnt != 32'hFFFF_FFFF)) begin
            r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
        end
    end

    assign mispredict_cnt_o = r_mispredict_cnt;
`endif

    assign pred_ready_o = ~w_full;
    assign count_o      = r_wr_ptr - r_rd_ptr;
    assign bht_w_o      = r_bht_w;
    assign bht_w_pc_o   = r_bht_w_pc;
    assign correct_o    = r_correct;
    assign underflow_o  = r_underflow;

endmodule

// File: tb/tb_bp_bht_update_queue.sv
// Directed self-checking bench for bp_bht_update_queue (PC_W=32, DEPTH_LG=3).
module tb_bp_bht_update_queue;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic        pred_v_i;
    logic        pred_ready_o;
    logic [31:0] pred_pc_i;
    logic        pred_taken_i;
    logic        res_v_i;
    logic        res_taken_i;
    logic        bht_w_o;
    logic [31:0] bht_w_pc_o;
    logic        correct_o;
    logic [3:0]  count_o;
    logic        underflow_o;
`ifdef BP_UPDQ_STATS_EN
    logic [31:0] mispredict_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    bp_bht_update_queue #(.PC_W(32), .DEPTH_LG(3)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .flush_i          (flush_i),
        .pred_v_i         (pred_v_i),
        .pred_ready_o     (pred_ready_o),
        .pred_pc_i        (pred_pc_i),
        .pred_taken_i     (pred_taken_i),
        .res_v_i          (res_v_i),
        .res_taken_i      (res_taken_i),
        .bht_w_o          (bht_w_o),
        .bht_w_pc_o       (bht_w_pc_o),
        .correct_o        (correct_o),
        .count_o          (count_o),
`ifdef BP_UPDQ_STATS_EN
        .mispredict_cnt_o (mispredict_cnt_o),
`endif
        .underflow_o      (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        flush_i = 1'b0; pred_v_i = 1'b0; res_v_i = 1'b0;
        pred_pc_i = 32'h0; pred_taken_i = 1'b0; res_taken_i = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic tk);
        pred_v_i = 1'b1; pred_pc_i = pc; pred_taken_i = tk;
    endtask

    task automatic resolve(input logic tk);
        res_v_i = 1'b1; res_taken_i = tk;
    endtask

    initial begin
        reset_i = 1'b1;
        idle();
        #12;
        chk("rst_count", count_o, 0);
        chk("rst_ready", pred_ready_o, 1);
        chk("rst_bht_w", bht_w_o, 0);
        chk("rst_pc", bht_w_pc_o, 0);
        chk("rst_correct", correct_o, 0);
        chk("rst_underflow", underflow_o, 0);
`ifdef BP_UPDQ_STATS_EN
        chk("rst_miscnt", mispredict_cnt_o, 0);
`endif
        reset_i = 1'b0;
        tick();

        // 1: correct prediction
        push(32'h100, 1'b1); tick(); idle();
        chk("t1_count1", count_o, 1);
        resolve(1'b1); tick(); idle();
        chk("t1_bht_w", bht_w_o, 1);
        chk("t1_pc", bht_w_pc_o, 32'h100);
        chk("t1_correct", correct_o, 1);
        chk("t1_count0", count_o, 0);
        tick();
        chk("t1_bht_w_low", bht_w_o, 0);
        chk("t1_pc_hold", bht_w_pc_o, 32'h100);

        // 2: misprediction
        push(32'h200, 1'b0); tick(); idle();
        resolve(1'b1); tick(); idle();
        chk("t2_bht_w", bht_w_o, 1);
        chk("t2_pc", bht_w_pc_o, 32'h200);
        chk("t2_correct", correct_o, 0);
        tick();
`ifdef BP_UPDQ_STATS_EN
        chk("t2_miscnt", mispredict_cnt_o, 1);
`endif

        // 3: fill, overflow drop, push refused while full even with a pop
        for (int i = 0; i < 8; i++) begin
            push(32'h300 + 32'(i * 4), i[0]); tick();
        end
        idle();
        chk("t3_full_count", count_o, 8);
        chk("t3_full_ready", pred_ready_o, 0);
        push(32'hDEAD, 1'b1); tick(); idle();
        chk("t3_drop_count", count_o, 8);
        push(32'hBEEF, 1'b1); resolve(1'b1); tick(); idle();
        chk("t3_pp_count", count_o, 7);
        chk("t3_pp_bht_w", bht_w_o, 1);
        chk("t3_pp_pc", bht_w_pc_o, 32'h300);
        chk("t3_pp_correct", correct_o, 0);
        for (int i = 1; i < 8; i++) begin
            resolve(1'b1); tick();
            chk("t3_drain_pc", bht_w_pc_o, 32'h300 + 32'(i * 4));
            chk("t3_drain_correct", correct_o, {63'd0, i[0]});
        end
        idle(); tick();
        chk("t3_empty_count", count_o, 0);
        chk("t3_no_underflow", underflow_o, 0);

        // 4: back-to-back resolves, then wrap with simultaneous push+pop
        push(32'h10, 1'b1); tick();
        push(32'h14, 1'b0); tick();
        push(32'h18, 1'b1); tick(); idle();
        resolve(1'b1); tick();
        chk("t4_w0", bht_w_o, 1); chk("t4_pc0", bht_w_pc_o, 32'h10);
        tick();
        chk("t4_w1", bht_w_o, 1); chk("t4_pc1", bht_w_pc_o, 32'h14);
        tick(); idle();
        chk("t4_w2", bht_w_o, 1); chk("t4_pc2", bht_w_pc_o, 32'h18);
        push(32'h1000, 1'b0); tick();
        for (int i = 1; i < 20; i++) begin
            push(32'h1000 + 32'(i), i[0]); resolve(1'b0); tick();
            chk("t4_wrap_pc", bht_w_pc_o, 32'h1000 + 32'(i - 1));
            chk("t4_wrap_correct", correct_o, {63'd0, ~i[0] ^ 1'b1 ^ 1'b1 ^ 1'b1});
            chk("t4_wrap_count", count_o, 1);
        end
        idle(); resolve(1'b0); tick(); idle();
        chk("t4_last_pc", bht_w_pc_o, 32'h1013);
        chk("t4_last_correct", correct_o, 0);
        chk("t4_last_count", count_o, 0);

        // 5: flush beats same-cycle push and pop, then underflow is sticky
        for (int i = 0; i < 4; i++) begin
            push(32'h400 + 32'(i * 4), 1'b1); tick();
        end
        idle();
        chk("t5_count4", count_o, 4);
        flush_i = 1'b1; push(32'h4F0, 1'b1); resolve(1'b1); tick(); idle();
        chk("t5_flush_count", count_o, 0);
        chk("t5_flush_bht_w", bht_w_o, 0);
        chk("t5_flush_no_uf", underflow_o, 0);
        resolve(1'b1); tick(); idle();
        chk("t5_uf_set", underflow_o, 1);
        chk("t5_uf_no_w", bht_w_o, 0);
        chk("t5_uf_count", count_o, 0);
        tick(); tick();
        chk("t5_uf_sticky", underflow_o, 1);

        // 6: asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) begin
            push(32'h600 + 32'(i * 4), 1'b0); tick();
        end
        idle(); resolve(1'b0); tick(); idle();
        chk("t6_pre_count", count_o, 3);
        chk("t6_pre_bht_w", bht_w_o, 1);
        #2 reset_i = 1'b1;
        #1;
        chk("t6_rst_count", count_o, 0);
        chk("t6_rst_bht_w", bht_w_o, 0);
        chk("t6_rst_pc", bht_w_pc_o, 0);
        chk("t6_rst_uf", underflow_o, 0);
        chk("t6_rst_ready", pred_ready_o, 1);
        tick();
        reset_i = 1'b0;
        push(32'h500, 1'b1); tick(); idle();
        chk("t6_post_count", count_o, 1);
        resolve(1'b1); tick(); idle();
        chk("t6_post_w", bht_w_o, 1);
        chk("t6_post_pc", bht_w_pc_o, 32'h500);
        chk("t6_post_correct", correct_o, 1);
        chk("t6_post_uf", underflow_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
